// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine: FSM state codes,
// metacharacter codes and the ASCII case-folding helper.
package sme_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_JUDGE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0] SP     = 8'h20;
    localparam logic [7:0] CARET  = 8'h5E;
    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] STAR   = 8'h2A;

    // Folds 'A'..'Z' to lower case; every other code passes through.
    function automatic logic [31:0] fold_case(input logic [31:0] c);
        if (c >= 32'h41 && c <= 32'h5A) begin
            return c + 32'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/sme_char_cmp.sv
// Single pattern-char versus string-char comparator: '.' matches anything,
// otherwise literal equality, optionally after case folding of both sides.
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] pat_char,
    input  logic [CW-1:0] str_char,
    input  logic          nocase,
    output logic          eq
);

    logic [31:0] pat_fold;
    logic [31:0] str_fold;

    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results; clocked blocks use '<=' so every register updates together.
    always_comb begin
        pat_fold = 32'(pat_char);
        str_fold = 32'(str_char);
        if (nocase) begin
            pat_fold = fold_case(pat_fold);
            str_fold = fold_case(str_fold);
        end
        eq = (pat_char == CW'(DOT)) || (pat_fold == str_fold);
    end

endmodule

// File: rtl/sme_param.sv
// Parametrised string-matching engine: loads a subject string and patterns,
// then searches leftmost-first with lazy multi-'*' backtracking, one step/cycle.
module sme_param
    import sme_pkg::*;
#(
    parameter int CW      = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    localparam int IW     = $clog2(STR_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] chardata,
    input  logic          isstring,
    input  logic          ispattern,
    input  logic          nocase,
    output logic          busy,
    output logic          valid,
    output logic          match,
    output logic [IW-1:0] match_index,
    output logic [IW-1:0] match_len,
    output logic          overflow
);

    localparam int SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam logic [IW-1:0] STR_LIM = IW'(STR_MAX);
    localparam logic [IW-1:0] PAT_LIM = IW'(PAT_MAX);

    logic [1:0]    state;
    logic [CW-1:0] str_mem [STR_MAX];
    logic [CW-1:0] pat_mem [PAT_MAX];
    logic [IW-1:0] slen, plen, st, si, pi, star_pi, star_si, first_idx;
    logic          have_star, first_set, star_first, nc;
    logic          str_fresh, pat_fresh, load_fresh;

    logic           to_judge, str_beat, pat_beat, str_we, pat_we;
    logic [SAW-1:0] str_wa;
    logic [PAW-1:0] pat_wa;
    logic           si_in, prev_sp, next_sp, cmp_eq, at_end;
    logic           step_star, step_pass, step_consume;
    logic [CW-1:0]  sc, pc, prev_char;
    logic [IW-1:0]  si_m1, res_idx;

    assign busy = (state != ST_LOAD);

    // A loaded pattern ends on the first beat without ispattern; isstring wins ties.
    always_comb begin
        to_judge = (state == ST_LOAD) && !pat_fresh && !ispattern;
        str_beat = (state == ST_LOAD) && !to_judge && isstring;
        pat_beat = (state == ST_LOAD) && !to_judge && !isstring && ispattern;
        str_wa   = str_fresh ? '0 : slen[SAW-1:0];
        pat_wa   = pat_fresh ? '0 : plen[PAW-1:0];
        str_we   = str_beat && (str_fresh || slen < STR_LIM);
        pat_we   = pat_beat && (pat_fresh || plen < PAT_LIM);
    end

    sme_char_cmp #(.CW(CW)) u_cmp (
        .pat_char (pc),
        .str_char (sc),
        .nocase   (nc),
        .eq       (cmp_eq)
    );

    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        si_in        = (si < slen);
        si_m1        = si - 1'b1;
        sc           = si_in ? str_mem[si[SAW-1:0]] : '0;
        prev_char    = str_mem[si_m1[SAW-1:0]];
        pc           = pat_mem[pi[PAW-1:0]];
        prev_sp      = (si == '0) || (prev_char == CW'(SP));
        next_sp      = !si_in || (sc == CW'(SP));
        at_end       = (pi == plen);
        res_idx      = first_set ? first_idx : si;
        step_star    = 1'b0;
        step_pass    = 1'b0;
        step_consume = 1'b0;
        if (!at_end) begin
            if (pc == CW'(STAR)) begin
                step_star = 1'b1;
            end else if (pc == CW'(CARET)) begin
                step_pass = prev_sp;
            end else if (pc == CW'(DOLLAR)) begin
                step_pass = next_sp;
            end else begin
                step_consume = si_in && cmp_eq;
            end
        end
    end

    // NOTE: the character arrays are never reset; slen/plen alone mark live entries.
    always_ff @(posedge clk) begin
        if (str_we) str_mem[str_wa] <= chardata;
        if (pat_we) pat_mem[pat_wa] <= chardata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            slen        <= '0;
            plen        <= '0;
            st          <= '0;
            si          <= '0;
            pi          <= '0;
            star_pi     <= '0;
            star_si     <= '0;
            first_idx   <= '0;
            have_star   <= 1'b0;
            first_set   <= 1'b0;
            star_first  <= 1'b0;
            nc          <= 1'b0;
            str_fresh   <= 1'b1;
            pat_fresh   <= 1'b1;
            load_fresh  <= 1'b1;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_len   <= '0;
            overflow    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (str_beat || pat_beat) begin
                        load_fresh <= 1'b0;
                        if (load_fresh) overflow <= 1'b0;
                    end
                    if (to_judge) begin
                        state     <= ST_JUDGE;
                        st        <= '0;
                        si        <= '0;
                        pi        <= '0;
                        have_star <= 1'b0;
                        first_set <= 1'b0;
                    end else if (str_beat) begin
                        str_fresh <= 1'b0;
                        if (str_fresh) slen <= IW'(1);
                        else if (slen < STR_LIM) slen <= slen + 1'b1;
                        else overflow <= 1'b1;
                    end else if (pat_beat) begin
                        pat_fresh <= 1'b0;
                        if (pat_fresh) begin
                            plen <= IW'(1);
                            nc   <= nocase;
                        end else if (plen < PAT_LIM) begin
                            plen <= plen + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_JUDGE: begin
                    if (at_end) begin
                        state       <= ST_DONE;
                        valid       <= 1'b1;
                        match       <= 1'b1;
                        match_index <= res_idx;
                        match_len   <= si - res_idx;
                    end else if (step_star) begin
                        star_pi    <= pi;
                        star_si    <= si;
                        star_first <= first_set;
                        have_star  <= 1'b1;
                        pi         <= pi + 1'b1;
                    end else if (step_pass) begin
                        pi <= pi + 1'b1;
                    end else if (step_consume) begin
                        if (!first_set) begin
                            first_idx <= si;
                            first_set <= 1'b1;
                        end
                        si <= si + 1'b1;
                        pi <= pi + 1'b1;
                    end else if (have_star && star_si < slen) begin
                        // Let the latest star swallow one more char; forget any start found after it.
                        star_si   <= star_si + 1'b1;
                        si        <= star_si + 1'b1;
                        pi        <= star_pi + 1'b1;
                        first_set <= star_first;
                    end else if (st == slen) begin
                        state       <= ST_DONE;
                        valid       <= 1'b1;
                        match       <= 1'b0;
                        match_index <= '0;
                        match_len   <= '0;
                    end else begin
                        st        <= st + 1'b1;
                        si        <= st + 1'b1;
                        pi        <= '0;
                        have_star <= 1'b0;
                        first_set <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state      <= ST_LOAD;
                    str_fresh  <= 1'b1;
                    pat_fresh  <= 1'b1;
                    load_fresh <= 1'b1;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule
